// File: rtl/operand_pair_loader.sv
// ---------------------------------------------------------------------------
// OperandPairLoader
//
// Collects two consecutive bytes from an upstream valid/ready stream and
// presents them as a registered operand pair to a downstream boolean-logic
// stage. The first accepted byte becomes operandA, the second operandB. The
// pair is held stable while the downstream stage applies backpressure. The
// block counts every consumed pair modulo 256.
//
// Ports
//   clk         sole clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   flush       synchronous abort of any partially loaded or held pair
//   in_data     upstream byte data (W bits)
//   in_valid    upstream data valid
//   in_ready    block accepts in_data this cycle
//   operandA    first operand of the current pair (registered)
//   operandB    second operand of the current pair (registered)
//   pair_valid  operandA/operandB form a complete pair
//   pair_ready  downstream consumes the pair this cycle
//   pair_count  number of consumed pairs, modulo 256
// ---------------------------------------------------------------------------
module operand_pair_loader #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] operandA,
  output logic [W-1:0] operandB,
  output logic         pair_valid,
  input  logic         pair_ready,
  output logic [7:0]   pair_count
);

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_nextState;
  logic [W-1:0] r_operandA;
  logic [W-1:0] r_operandB;
  logic [7:0]   r_pairCount;
  logic         w_inReady;
  logic         w_pairValid;
  logic         w_inHs;
  logic         w_pairHs;
  logic         w_loadA;
  logic         w_loadB;

  // Handshake decoding and next-state selection. pair_valid depends on the
  // state alone. In HOLD the upstream side is only ready when the downstream
  // side is consuming, which is what lets a new operandA be captured in the
  // same cycle the old pair leaves, so a continuous stream runs without a
  // bubble. Flush forces in_ready low and masks the pair handshake, so
  // nothing is loaded or counted during a flush cycle.
  always_comb begin
    w_nextState = r_state;
    w_loadA     = 1'b0;
    w_loadB     = 1'b0;
    w_pairValid = (r_state == HOLD);
    w_inReady   = 1'b0;

    if (!flush) begin
      case (r_state)
        WAIT_A:  w_inReady = 1'b1;
        WAIT_B:  w_inReady = 1'b1;
        HOLD:    w_inReady = pair_ready;
        default: w_inReady = 1'b0;
      endcase
    end

    w_inHs   = in_valid & w_inReady;
    w_pairHs = w_pairValid & pair_ready & ~flush;

    if (flush) begin
      w_nextState = WAIT_A;
    end else begin
      case (r_state)
        WAIT_A: begin
          if (w_inHs) begin
            w_loadA     = 1'b1;
            w_nextState = WAIT_B;
          end
        end
        WAIT_B: begin
          if (w_inHs) begin
            w_loadB     = 1'b1;
            w_nextState = HOLD;
          end
        end
        HOLD: begin
          if (w_pairHs && w_inHs) begin
            w_loadA     = 1'b1;
            w_nextState = WAIT_B;
          end else if (w_pairHs) begin
            w_nextState = WAIT_A;
          end
        end
        default: w_nextState = WAIT_A;
      endcase
    end
  end

  // State register. Reset wins over everything; flush handling already lives
  // in the next-state logic above.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WAIT_A;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Operand registers only move on an accepted byte, which keeps the pair
  // frozen for the whole time it sits in HOLD. Flush leaves them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_operandA <= '0;
      r_operandB <= '0;
    end else begin
      if (w_loadA) begin
        r_operandA <= in_data;
      end
      if (w_loadB) begin
        r_operandB <= in_data;
      end
    end
  end

  // Consumed-pair counter, wrapping naturally at 8 bits. A flushed or
  // reset-discarded pair never produces a pair handshake, so it is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pairCount <= 8'd0;
    end else if (w_pairHs) begin
      r_pairCount <= r_pairCount + 8'd1;
    end
  end

  assign in_ready   = w_inReady;
  assign pair_valid = w_pairValid;
  assign operandA   = r_operandA;
  assign operandB   = r_operandB;
  assign pair_count = r_pairCount;

endmodule

// File: tb/tb_operand_pair_loader.sv
// ---------------------------------------------------------------------------
// TbOperandPairLoader
//
// Directed bench for operand_pair_loader. Inputs are driven on the falling
// edge and outputs are sampled shortly afterwards, so every expectation
// describes the state that exists before the next rising edge. A table of
// vectors covers loading, backpressure, back-to-back streaming and flush; hand
// sequences cover counter wrap and reset while a pair is held.
// ---------------------------------------------------------------------------
module tb_operand_pair_loader;

  localparam int W = 8;
  localparam int NUM_VECS = 30;

  logic         clk;
  logic         rst;
  logic         flush;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] operandA;
  logic [W-1:0] operandB;
  logic         pair_valid;
  logic         pair_ready;
  logic [7:0]   pair_count;

  int errorCount = 0;
  int checkCount = 0;

  typedef struct {
    logic       flush;
    logic       inValid;
    logic [7:0] inData;
    logic       pairReady;
    logic       expInReady;
    logic       expPairValid;
    logic [7:0] expA;
    logic [7:0] expB;
    logic [7:0] expCount;
  } vec_t;

  vec_t vecs [NUM_VECS];

  logic [7:0] expCount;

  operand_pair_loader #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operandA   (operandA),
    .operandB   (operandB),
    .pair_valid (pair_valid),
    .pair_ready (pair_ready),
    .pair_count (pair_count)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs on the falling edge, then let them settle.
  task automatic applyStimulus(input logic rstIn, input logic flushIn,
                               input logic validIn, input logic [7:0] dataIn,
                               input logic pairReadyIn);
    @(negedge clk);
    rst        = rstIn;
    flush      = flushIn;
    in_valid   = validIn;
    in_data    = dataIn;
    pair_ready = pairReadyIn;
    #1;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // One full pair: two accepted bytes, then a cycle in HOLD where the
  // downstream side consumes it.
  task automatic sendPair(input logic [7:0] a, input logic [7:0] b);
    applyStimulus(1'b0, 1'b0, 1'b1, a, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, b, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("sendPair pairValid", {31'd0, pair_valid}, 32'd1);
    checkOutput("sendPair operandA", {24'd0, operandA}, {24'd0, a});
    checkOutput("sendPair operandB", {24'd0, operandB}, {24'd0, b});
    checkOutput("sendPair count", {24'd0, pair_count}, {24'd0, expCount});
    expCount = expCount + 8'd1;
  endtask

  initial begin
    // Each row: flush, in_valid, in_data, pair_ready | in_ready, pair_valid,
    // operandA, operandB, pair_count as seen before the coming rising edge.
    // Basic load 3D/A6 consumed immediately.
    vecs[0]  = '{1'b0, 1'b1, 8'h3D, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'd0};
    vecs[1]  = '{1'b0, 1'b1, 8'hA6, 1'b1, 1'b1, 1'b0, 8'h3D, 8'h00, 8'd0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h3D, 8'hA6, 8'd0};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h3D, 8'hA6, 8'd1};
    // Backpressure: reload 3D/A6 and stall five cycles with FF offered.
    vecs[4]  = '{1'b0, 1'b1, 8'h3D, 1'b0, 1'b1, 1'b0, 8'h3D, 8'hA6, 8'd1};
    vecs[5]  = '{1'b0, 1'b1, 8'hA6, 1'b0, 1'b1, 1'b0, 8'h3D, 8'hA6, 8'd1};
    vecs[6]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h3D, 8'hA6, 8'd1};
    vecs[7]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h3D, 8'hA6, 8'd1};
    vecs[8]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h3D, 8'hA6, 8'd1};
    vecs[9]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h3D, 8'hA6, 8'd1};
    vecs[10] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h3D, 8'hA6, 8'd1};
    vecs[11] = '{1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h3D, 8'hA6, 8'd1};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3D, 8'hA6, 8'd2};
    // Back-to-back stream 01,02,03,04 with 03 accepted at the HOLD handshake.
    vecs[13] = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 8'h3D, 8'hA6, 8'd2};
    vecs[14] = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 8'h01, 8'hA6, 8'd2};
    vecs[15] = '{1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h01, 8'h02, 8'd2};
    vecs[16] = '{1'b0, 1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 8'h03, 8'h02, 8'd3};
    vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03, 8'h04, 8'd3};
    vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h03, 8'h04, 8'd4};
    // Flush in WAIT_B after 11, then 22,33 forms the pair.
    vecs[19] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h03, 8'h04, 8'd4};
    vecs[20] = '{1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 8'h11, 8'h04, 8'd4};
    vecs[21] = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h11, 8'h04, 8'd4};
    vecs[22] = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h22, 8'h04, 8'd4};
    vecs[23] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 8'h33, 8'd4};
    vecs[24] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h22, 8'h33, 8'd5};
    // Extreme values 00/FF with an idle cycle in WAIT_B, then flush in HOLD.
    vecs[25] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h22, 8'h33, 8'd5};
    vecs[26] = '{1'b0, 1'b0, 8'h77, 1'b0, 1'b1, 1'b0, 8'h00, 8'h33, 8'd5};
    vecs[27] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 8'h33, 8'd5};
    vecs[28] = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, 8'd5};
    vecs[29] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 8'd5};

    rst        = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    pair_ready = 1'b0;

    // Reset for two edges, then check the idle state right after release.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("reset pairValid during", {31'd0, pair_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("reset inReady", {31'd0, in_ready}, 32'd1);
    checkOutput("reset pairValid", {31'd0, pair_valid}, 32'd0);
    checkOutput("reset operandA", {24'd0, operandA}, 32'd0);
    checkOutput("reset operandB", {24'd0, operandB}, 32'd0);
    checkOutput("reset count", {24'd0, pair_count}, 32'd0);

    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(1'b0, vecs[i].flush, vecs[i].inValid, vecs[i].inData,
                    vecs[i].pairReady);
      checkOutput($sformatf("row%0d inReady", i), {31'd0, in_ready},
                  {31'd0, vecs[i].expInReady});
      checkOutput($sformatf("row%0d pairValid", i), {31'd0, pair_valid},
                  {31'd0, vecs[i].expPairValid});
      checkOutput($sformatf("row%0d operandA", i), {24'd0, operandA},
                  {24'd0, vecs[i].expA});
      checkOutput($sformatf("row%0d operandB", i), {24'd0, operandB},
                  {24'd0, vecs[i].expB});
      checkOutput($sformatf("row%0d count", i), {24'd0, pair_count},
                  {24'd0, vecs[i].expCount});
    end

    // Counter wrap: keep consuming pairs until the 8-bit count returns to 0,
    // which passes through 255.
    expCount = 8'd5;
    do begin
      sendPair(expCount ^ 8'h5A, ~expCount);
    end while (expCount != 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("wrap count", {24'd0, pair_count}, 32'd0);
    checkOutput("wrap pairValid", {31'd0, pair_valid}, 32'd0);

    // Load one pair so the count is nonzero, then reset while holding a
    // second pair with pair_ready high on the same edge.
    sendPair(8'h12, 8'h34);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("preReset count", {24'd0, pair_count}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hC3, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("holdReset pairValid before", {31'd0, pair_valid}, 32'd1);
    checkOutput("holdReset operandA before", {24'd0, operandA}, 32'h0C3);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("holdReset pairValid", {31'd0, pair_valid}, 32'd0);
    checkOutput("holdReset operandA", {24'd0, operandA}, 32'd0);
    checkOutput("holdReset operandB", {24'd0, operandB}, 32'd0);
    checkOutput("holdReset count", {24'd0, pair_count}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("postReset inReady", {31'd0, in_ready}, 32'd1);
    checkOutput("postReset count", {24'd0, pair_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/operand_pair_loader.md
OPERAND_PAIR_LOADER -- requirements
Module: operand_pair_loader

Interface
REQ-001 SHALL have parameter W, default 8, giving the operand and byte width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port flush  input  1  synchronous abort of any partially loaded or held pair.
REQ-005 SHALL have port in_data  input  W  upstream byte stream data.
REQ-006 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port operandA  output  W  first operand of the current pair, registered.
REQ-009 SHALL have port operandB  output  W  second operand of the current pair, registered.
REQ-010 SHALL have port pair_valid  output  1  operandA/operandB form a complete pair for the downstream boolean-logic stage.
REQ-011 SHALL have port pair_ready  input  1  downstream consumes the pair this cycle.
REQ-012 SHALL have port pair_count  output  8  number of pairs consumed, modulo 256.

Function
REQ-013 SHALL implement three states: WAIT_A, WAIT_B and HOLD.
REQ-014 SHALL define an input handshake as in_valid AND in_ready on the same rising edge, and a pair handshake as pair_valid AND pair_ready on the same rising edge.
REQ-015 SHALL drive in_ready = 1 in WAIT_A and WAIT_B, in_ready = pair_ready in HOLD, and in_ready = 0 while flush = 1.
REQ-016 SHALL drive pair_valid = 1 only in HOLD; pair_valid is a pure function of state.
REQ-017 SHALL, in WAIT_A on an input handshake, load operandA <= in_data and move to WAIT_B.
REQ-018 SHALL, in WAIT_B on an input handshake, load operandB <= in_data and move to HOLD, so pair_valid rises the cycle after the second byte is accepted (1-cycle latency).
REQ-019 SHALL, in HOLD on a pair handshake without an input handshake, move to WAIT_A.
REQ-020 SHALL, in HOLD on a simultaneous pair handshake and input handshake, load operandA <= in_data and move to WAIT_B with no bubble.
REQ-021 SHALL keep operandA and operandB unchanged whenever pair_valid = 1 and pair_ready = 0, and keep both stable for as long as HOLD lasts.
REQ-022 SHALL, in WAIT_A and WAIT_B when in_valid = 0, hold state and operands.
REQ-023 SHALL increment pair_count by 1 on each pair handshake, wrapping from 255 to 0.
REQ-024 SHALL, when flush = 1 in any state, move to WAIT_A next cycle and ignore in_valid and pair_ready that cycle.
REQ-025 SHALL, on flush, leave the operand registers and pair_count unchanged, with a flushed pair not counted.
REQ-026 SHALL give rst priority over flush, and flush priority over all handshakes.
REQ-027 SHALL not depend on in_data bit contents; all W-bit values, including 0 and all-ones, are carried unmodified.

Reset
REQ-028 SHALL, while rst = 1 at a rising edge, set the state to WAIT_A, operandA = 0, operandB = 0 and pair_count = 0.
REQ-029 SHALL drive pair_valid = 0 during and after reset, and in_ready = 1 on the first cycle after rst deasserts.
REQ-030 SHALL, on reset asserted mid-operation in WAIT_B or HOLD, discard the pair with no pair handshake and no pair_count increment.

Verification
REQ-031 SHALL cover basic load: bytes 8'h3D then 8'hA6 with pair_ready = 1 -> pair_valid high one cycle with operandA = 3D, operandB = A6, then pair_count = 1.
REQ-032 SHALL cover backpressure: pair_ready = 0 for 5 cycles in HOLD while in_valid = 1 with data 8'hFF -> in_ready = 0, operands stay 3D/A6, and pair_count is unchanged until pair_ready = 1.
REQ-033 SHALL cover back-to-back: continuous in_valid stream 01,02,03,04 with pair_ready = 1 -> pairs (01,02) and (03,04) with no idle cycle between the acceptance of 02 and 03 at the HOLD handshake.
REQ-034 SHALL cover flush in WAIT_B after byte 8'h11, then bytes 22,33 -> pair is (22,33), never (11,22), and pair_count increments only once.
REQ-035 SHALL cover wrap: 256 consumed pairs -> pair_count goes 255 -> 0.
REQ-036 SHALL cover reset in HOLD with pair_ready = 1 on the same edge -> pair_count stays 0, pair_valid = 0 and operands = 0 next cycle.
